thiele_imem_loader: RTL and testbench

Initiator side of the CPU instruction-load method (loadInstr / EN_loadInstr / RDY_loadInstr) on the Thiele CPU core. It accepts a host byte stream, assembles big-endian 32-bit instruction words and issues them as {addr, instr} load transfers to addresses 0..DEPTH-1. Unused addresses are padded with PAD_WORD. The CPU is held idle for the whole load, so it never executes partially loaded imem.

---
 rtl/thiele_loader_pkg.sv | 24 ++
 rtl/thiele_imem_loader_if.sv | 38 +++
 rtl/thiele_word_assembler.sv | 30 +++
 rtl/thiele_imem_loader.sv | 128 ++++++++++++
 tb/tb_thiele_imem_loader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/thiele_loader_pkg.sv
// Thiele imem loader shared types.
// FSM states, status codes and load bus widths.
package thiele_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    ISSUE,
    PAD,
    DRAIN,
    RELEASE
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_PARTIAL  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  localparam logic [7:0] OPC_HALT = 8'hFF;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_WORD_W = 32;
  localparam int LOAD_W = IMEM_ADDR_W + IMEM_WORD_W;

endpackage

// File: rtl/thiele_imem_loader_if.sv
// Host byte stream plus CPU loadInstr method.
// master = loader side, slave = host/CPU side.
interface thiele_imem_loader_if
  import thiele_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int WORD_W = IMEM_WORD_W
);

  logic                     s_valid;
  logic [7:0]               s_data;
  logic                     s_last;
  logic                     s_ready;
  logic [ADDR_W+WORD_W-1:0] loadInstr_x_0;
  logic                     EN_loadInstr;
  logic                     RDY_loadInstr;

  modport master (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  RDY_loadInstr,
    output s_ready,
    output loadInstr_x_0,
    output EN_loadInstr
  );

  modport slave (
    output s_valid,
    output s_data,
    output s_last,
    output RDY_loadInstr,
    input  s_ready,
    input  loadInstr_x_0,
    input  EN_loadInstr
  );

endinterface

// File: rtl/thiele_word_assembler.sv
// Big-endian byte-to-word shifter.
// word_valid flags the cycle the 4th byte is accepted.
module thiele_word_assembler (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] byte_cnt;

  assign word_valid = accept & (byte_cnt == 2'd3);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      word     <= {word[23:0], data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/thiele_imem_loader.sv
// Thiele imem loader: byte stream to DEPTH loadInstr
// transfers, padding the tail, CPU held throughout.
module thiele_imem_loader
  import thiele_loader_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 8,
  parameter int          WORD_W   = 32,
  parameter logic [31:0] PAD_WORD = 32'h0000_0000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  thiele_imem_loader_if.master bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err,
  output logic [ADDR_W:0]     words_loaded
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state;
  logic [ADDR_W-1:0]   addr;
  logic                last_seen;
  logic [WORD_W-1:0]   word;
  logic                word_valid;
  logic                acc;
  logic                recv_acc;
  logic                partial;
  logic                clear;
  logic                xfer;

  assign bus.s_ready = (state == RECV) || (state == DRAIN);
  assign acc         = bus.s_valid & bus.s_ready;
  assign recv_acc    = acc & (state == RECV);
  assign partial     = recv_acc & bus.s_last & ~word_valid;
  assign clear       = ((state == IDLE) & start) | partial;

  assign bus.EN_loadInstr =
    ((state == ISSUE) || (state == PAD)) & bus.RDY_loadInstr;
  assign xfer = bus.EN_loadInstr;

  assign bus.loadInstr_x_0 =
    (state == ISSUE) ? {addr, word} :
    (state == PAD)   ? {addr, PAD_WORD} : '0;

  assign busy = (state != IDLE);
  assign done = (state == RELEASE);

  thiele_word_assembler u_asm (
    .CLK        (CLK),
    .RST        (RST),
    .clear      (clear),
    .accept     (recv_acc),
    .data       (bus.s_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      addr         <= '0;
      last_seen    <= 1'b0;
      err          <= ERR_OK;
      words_loaded <= '0;
      cpu_hold     <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addr         <= '0;
            err          <= ERR_OK;
            words_loaded <= '0;
            cpu_hold     <= 1'b1;
            state        <= RECV;
          end
        end
        RECV: begin
          if (recv_acc) begin
            if (word_valid) begin
              last_seen <= bus.s_last;
              state     <= ISSUE;
            end else if (bus.s_last) begin
              err   <= ERR_PARTIAL;
              state <= PAD;
            end
          end
        end
        ISSUE: begin
          if (xfer) begin
            words_loaded <= words_loaded + 1'b1;
            if (addr == LAST_ADDR) begin
              if (last_seen) begin
                state <= RELEASE;
              end else begin
                err   <= ERR_OVERFLOW;
                state <= DRAIN;
              end
            end else begin
              addr  <= addr + 1'b1;
              state <= last_seen ? PAD : RECV;
            end
          end
        end
        PAD: begin
          if (xfer) begin
            addr <= addr + 1'b1;
            if (addr == LAST_ADDR)
              state <= RELEASE;
          end
        end
        DRAIN: begin
          if (acc && bus.s_last)
            state <= RELEASE;
        end
        RELEASE: begin
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_thiele_imem_loader.sv
// Randomized bench for thiele_imem_loader against
// a whole-load reference model of the transfer list.
module tb_thiele_imem_loader;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic [8:0] words_loaded;

  thiele_imem_loader_if bus ();

  thiele_imem_loader dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int rdy_mode = 0;

  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0:       bus.RDY_loadInstr = 1'b1;
      1:       bus.RDY_loadInstr = ($urandom % 3) != 0;
      default: bus.RDY_loadInstr = 1'b0;
    endcase
  end

  logic [39:0] xq[$];
  int          done_cnt = 0;

  always @(negedge CLK) begin
    if (bus.EN_loadInstr === 1'b1) begin
      xq.push_back(bus.loadInstr_x_0);
      chk("en_rdy", bus.RDY_loadInstr, 1);
    end
    if (done === 1'b1)
      done_cnt++;
  end

  logic [7:0] stim [0:1099];

  task automatic fill_stim();
    for (int i = 0; i < 1100; i++)
      stim[i] = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic send_bytes(int lo, int hi, bit mark_last,
                            bit gaps);
    int i = lo;
    int budget = 0;
    while (i < hi && budget < 20000) begin
      bus.s_valid = gaps ? (($urandom % 4) != 0) : 1'b1;
      bus.s_data  = stim[i];
      bus.s_last  = mark_last && (i == hi - 1);
      start       = gaps && (($urandom % 8) == 0);
      @(negedge CLK);
      if (bus.s_valid && bus.s_ready)
        i++;
      @(posedge CLK);
      #1;
      budget++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    start       = 1'b0;
    chk("bytes_taken", i, hi);
  endtask

  task automatic wait_done(int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    chk("hold_at_done", cpu_hold, 1);
    @(negedge CLK);
    chk("done_one", done, 0);
    chk("hold_rel", cpu_hold, 0);
    chk("busy_idle", busy, 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic verify(int n, int d0);
    logic [39:0] e;
    int nw = n / 4;
    int bad = 0;
    int wl = (nw > 256) ? 256 : nw;
    int ex_err = (n > 1024) ? 2 : ((n % 4) != 0 ? 1 : 0);
    chk("xfer_cnt", xq.size(), 256);
    for (int a = 0; a < 256 && a < xq.size(); a++) begin
      if (a < nw)
        e = {a[7:0], stim[4*a], stim[4*a+1],
             stim[4*a+2], stim[4*a+3]};
      else
        e = {a[7:0], 32'h0000_0000};
      if (xq[a] !== e)
        bad++;
    end
    chk("xfer_bad", bad, 0);
    chk("err", err, ex_err);
    chk("words", words_loaded, wl);
    chk("done_cnt", done_cnt - d0, 1);
  endtask

  task automatic run_load(int n, bit gaps, int rmode);
    int d0;
    xq.delete();
    rdy_mode    = rmode;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    repeat (2) begin
      @(negedge CLK);
      chk("idle_srdy", bus.s_ready, 0);
    end
    @(posedge CLK);
    #1;
    bus.s_valid = 1'b0;
    d0 = done_cnt;
    pulse_start();
    send_bytes(0, n, 1'b1, gaps);
    wait_done(3000);
    verify(n, d0);
  endtask

  initial begin
    int d0;
    int n;
    RST               = 1'b1;
    start             = 1'b0;
    bus.s_valid       = 1'b0;
    bus.s_data        = 8'h00;
    bus.s_last        = 1'b0;
    bus.RDY_loadInstr = 1'b1;
    #1;
    chk("rst_hold", cpu_hold, 1);
    chk("rst_srdy", bus.s_ready, 0);
    chk("rst_en", bus.EN_loadInstr, 0);
    chk("rst_done", done, 0);
    chk("rst_data", bus.loadInstr_x_0, 0);
    chk("rst_err", err, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    fill_stim();
    stim[0] = 8'h00; stim[1] = 8'h00;
    stim[2] = 8'h00; stim[3] = 8'h01;
    stim[4] = 8'hFF; stim[5] = 8'h00;
    stim[6] = 8'h00; stim[7] = 8'h00;
    run_load(8, 1'b0, 0);
    chk("t1_x0", (xq.size() > 0) ? xq[0] : 40'hx,
        40'h00_0000_0001);
    chk("t1_x1", (xq.size() > 1) ? xq[1] : 40'hx,
        40'h01_FF00_0000);

    fill_stim();
    xq.delete();
    d0 = done_cnt;
    rdy_mode = 2;
    pulse_start();
    send_bytes(0, 4, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk("stall_en", bus.EN_loadInstr, 0);
      chk("stall_srdy", bus.s_ready, 0);
      chk("stall_data", bus.loadInstr_x_0,
          {8'h00, stim[0], stim[1], stim[2], stim[3]});
    end
    rdy_mode = 0;
    @(negedge CLK);
    chk("stall_go", bus.EN_loadInstr, 1);
    @(posedge CLK);
    #1;
    send_bytes(4, 8, 1'b1, 1'b0);
    wait_done(3000);
    verify(8, d0);

    fill_stim();
    run_load(6, 1'b1, 1);
    fill_stim();
    run_load(1028, 1'b1, 1);
    fill_stim();
    run_load(1024, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      fill_stim();
      n = $urandom_range(1, 1030);
      run_load(n, 1'b1, 1);
    end

    fill_stim();
    xq.delete();
    rdy_mode = 0;
    pulse_start();
    send_bytes(0, 64, 1'b0, 1'b0);
    @(negedge CLK);
    rdy_mode = 2;
    @(posedge CLK);
    #1;
    send_bytes(64, 68, 1'b0, 1'b0);
    #1;
    rdy_mode = 0;
    bus.RDY_loadInstr = 1'b1;
    #1;
    chk("pre_en", bus.EN_loadInstr, 1);
    chk("pre_addr", bus.loadInstr_x_0[39:32], 8'h10);
    #1;
    RST = 1'b1;
    #1;
    chk("arst_en", bus.EN_loadInstr, 0);
    chk("arst_hold", cpu_hold, 1);
    chk("arst_busy", busy, 0);
    chk("arst_srdy", bus.s_ready, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    fill_stim();
    n = $urandom_range(100, 300);
    run_load(n, 1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
